pu_msp430_pmem_arbiter: RTL and testbench
=========================================

# pu_msp430_pmem_arbiter

Single-port sharing controller for the program-memory dual-port RAM (`pu_msp430_ram_p2`). It arbitrates one RAM port between requester A (CPU frontend, high priority) and requester B (debug/DMA loader, low priority). Arbitration is fixed-priority with a starvation guard and an optional lock for bursts. It drives the port's active-high enable and byte write enables and returns read data with one cycle of latency.

## Interface
Parameters:
- `ADDR_MSB`, default 11: MSB of the word address; matches the RAM port width.
- `MAX_WAIT`, default 4: consecutive blocked cycles of B after which B takes priority over A (range 1..15).

Ports:
- `mclk` in 1: clock. One clock domain; reset is synchronous and active-high.
- `puc_rst` in 1: synchronous active-high reset.
- `req_a` / `req_b` in 1: access request. Held until granted.
- `we_a` / `we_b` in 2: byte write enables; 0 means read.
- `addr_a` / `addr_b` in ADDR_MSB+1: word address.
- `din_a` / `din_b` in 16: write data.
- `lock_a` / `lock_b` in 1: when granted with lock, the requester keeps exclusive ownership.
- `gnt_a` / `gnt_b` out 1: combinational grant; the access completes at this clock edge.
- `rvalid_a` / `rvalid_b` out 1: read data valid, one cycle after a granted read.
- `rdata` out 16: `ram_dout` passed through; qualify it with `rvalid_x`.
- `ram_en` out 1: RAM port enable.
- `ram_we` out 2: RAM byte write enables.
- `ram_addr` out ADDR_MSB+1: RAM address.
- `ram_din` out 16: RAM write data.
- `ram_dout` in 16: RAM read data.

## Operation
- States: `IDLE`, `OWN_A`, `OWN_B`.
- IDLE grant rule:
  - If `wait_cnt == MAX_WAIT` and `req_b` is high, grant B.
  - Otherwise, if `req_a` is high, grant A.
  - Otherwise, if `req_b` is high, grant B.
- In `OWN_X`, only X can be granted. The other requester is blocked even if X is idle.
- Transitions:
  - IDLE → OWN_X when X is granted with `lock_x`=1.
  - OWN_X → IDLE when X is granted with `lock_x`=0 (that access completes), or when `req_x`=0 (release cycle, no grant to anyone).
  - Reset → IDLE from any state.
- At most one grant per cycle. `gnt_a & gnt_b` is never 1.
- RAM mux: `ram_en` = `gnt_a | gnt_b`. `ram_we`, `ram_addr` and `ram_din` come from the granted requester. With no grant, `ram_we`, `ram_addr` and `ram_din` are 0.
- `wait_cnt` (4 bits):
  - Increments, saturating at MAX_WAIT, when `req_b & ~gnt_b`.
  - Clears when `gnt_b` is high or `req_b` is low.
  - Keeps counting during `OWN_A`, but the override applies only in IDLE.
- `rvalid_x` is a register: `rvalid_x` <= `gnt_x & (we_x == 0)`. Writes never produce rvalid.
- A byte write (`we` = 01 or 10) is passed through unchanged. Merge semantics belong to the RAM.

## Timing
- Grant is combinational from the current state and inputs; there are no wait cycles when the port is free.
- Read latency: address at edge N, `rdata` and `rvalid_x` valid during cycle N+1.
- Back-to-back granted reads from one requester give one `rvalid` per cycle, with no bubble.
- Reset values: state IDLE, `wait_cnt` 0, `rvalid_a`/`rvalid_b` 0.
- While `puc_rst` is high, `gnt_a`, `gnt_b` and `ram_en` are forced to 0.
- Reset mid-lock: ownership is dropped. After reset, plain priority applies.
- Simultaneous requests in IDLE with `wait_cnt < MAX_WAIT`: A wins and `wait_cnt` increments.
- `req_x` deasserted without a grant is legal: the request is withdrawn, and for B, `wait_cnt` clears.

## Structure
- Package `pu_msp430_pmem_arb_pkg`:
  - state enum `pmem_arb_state_t` (IDLE, OWN_A, OWN_B);
  - localparam `WAIT_CNT_W` = 4.
- Single module, no sub-module. The `pu_msp430_ram_p2` instance sits at the parent level, with this block wired to its port B.

## Test plan
- Solo read: `req_b`=1, `addr_b`=0x010, `we_b`=0, RAM holds 0xBEEF → `gnt_b`=1 in cycle 0; cycle 1 has `rvalid_b`=1 and `rdata`=0xBEEF.
- Priority and starvation: `req_a` and `req_b` held high continuously with MAX_WAIT=4 → A is granted 4 cycles, B on cycle 5, then A for 4 more, and so on. `wait_cnt` returns to 0 after each B grant.
- Lock burst: B is granted with `lock_b`=1 and performs 3 writes (`we_b`=11, addr 0x20..0x22, data 0x1111..0x3333) while `req_a`=1 → `gnt_a` stays 0 throughout. The last access has `lock_b`=0; A is granted the next cycle. Readback returns the written data.
- Byte write: `we_a`=01, `din_a`=0xAA55 to an address holding 0x1234 → `ram_we`=01 that cycle, no `rvalid_a`, readback 0x1255.
- Lock release by dropping request: OWN_A, then `req_a`=0 with `req_b`=1 → no grant that cycle, state IDLE, `gnt_b`=1 the following cycle.
- Reset mid-lock: assert `puc_rst` for 1 cycle in OWN_B while `req_a` is high → `gnt_*` and `ram_en` are 0 during reset, `rvalid` is 0, and A is granted the first cycle after reset.

Source files
------------

// File: rtl/pu_msp430_pmem_arb_pkg.sv
// Shared types and constants for the program-memory port arbiter.
package pu_msp430_pmem_arb_pkg;

  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    OWN_A,
    OWN_B
  } pmem_arb_state_t;

endpackage

// File: rtl/pu_msp430_pmem_arbiter.sv
// Shares one program-memory RAM port between the CPU frontend (A, high
// priority) and a debug/DMA loader (B), with a starvation guard and burst lock.
module pu_msp430_pmem_arbiter
  import pu_msp430_pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_MSB = 11,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                mclk,
  input  logic                puc_rst,
  input  logic                req_a,
  input  logic [1:0]          we_a,
  input  logic [ADDR_MSB:0]   addr_a,
  input  logic [15:0]         din_a,
  input  logic                lock_a,
  input  logic                req_b,
  input  logic [1:0]          we_b,
  input  logic [ADDR_MSB:0]   addr_b,
  input  logic [15:0]         din_b,
  input  logic                lock_b,
  output logic                gnt_a,
  output logic                gnt_b,
  output logic                rvalid_a,
  output logic                rvalid_b,
  output logic [15:0]         rdata,
  output logic                ram_en,
  output logic [1:0]          ram_we,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic [15:0]         ram_din,
  input  logic [15:0]         ram_dout
);

  localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

  pmem_arb_state_t         state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    rvalid_a_q, rvalid_a_d;
  logic                    rvalid_b_q, rvalid_b_d;
  logic                    wait_at_max;

  assign wait_at_max = (wait_cnt_q == MAX_WAIT_C);

  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    state_d = state_q;

    unique case (state_q)
      IDLE: begin
        if (wait_at_max && req_b)  gnt_b = 1'b1;
        else if (req_a)            gnt_a = 1'b1;
        else if (req_b)            gnt_b = 1'b1;
      end
      OWN_A:   gnt_a = req_a;
      OWN_B:   gnt_b = req_b;
      default: ;
    endcase

    if (puc_rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end

    // Owner leaves on an unlocked access or on a request-drop release cycle.
    unique case (state_q)
      IDLE: begin
        if (gnt_a && lock_a)       state_d = OWN_A;
        else if (gnt_b && lock_b)  state_d = OWN_B;
      end
      OWN_A:   if (!req_a || !lock_a) state_d = IDLE;
      OWN_B:   if (!req_b || !lock_b) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req_b || gnt_b)   wait_cnt_d = '0;
    else if (!wait_at_max) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_comb begin
    rvalid_a_d = gnt_a && (we_a == 2'b00);
    rvalid_b_d = gnt_b && (we_b == 2'b00);
  end

  always_comb begin
    ram_we   = '0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt_a) begin
      ram_we   = we_a;
      ram_addr = addr_a;
      ram_din  = din_a;
    end else if (gnt_b) begin
      ram_we   = we_b;
      ram_addr = addr_b;
      ram_din  = din_b;
    end
  end

  assign ram_en   = gnt_a | gnt_b;
  assign rdata    = ram_dout;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

endmodule

// File: tb/tb_pu_msp430_pmem_arbiter.sv
// Bench for the program-memory arbiter: behavioural RAM, ownership/priority
// reference model, directed scenarios followed by randomized traffic.
module tb_pu_msp430_pmem_arbiter;

  localparam int unsigned AMSB = 11;
  localparam int unsigned MAXW = 4;

  logic              mclk = 1'b0;
  logic              puc_rst;
  logic              req_a, req_b, lock_a, lock_b;
  logic [1:0]        we_a, we_b;
  logic [AMSB:0]     addr_a, addr_b;
  logic [15:0]       din_a, din_b;
  logic              gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [15:0]       rdata;
  logic              ram_en;
  logic [1:0]        ram_we;
  logic [AMSB:0]     ram_addr;
  logic [15:0]       ram_din;
  logic [15:0]       ram_dout;

  always #5 mclk = ~mclk;

  pu_msp430_pmem_arbiter #(.ADDR_MSB(AMSB), .MAX_WAIT(MAXW)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .lock_a(lock_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .lock_b(lock_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM with registered read (old data on write).
  logic [15:0]   mem [0:4095];
  logic          pl_en;
  logic [AMSB:0] pl_addr;
  logic [15:0]   pl_data;

  always @(posedge mclk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      ram_dout <= mem[ram_addr];
      if (ram_we[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (ram_we[1]) mem[ram_addr][15:8] <= ram_din[15:8];
    end
  end

  // Reference model state: who owns the port, how long B has been refused.
  logic [15:0] shadow [0:4095];
  int          owner;      // 0 none, 1 A, 2 B
  int          blocked;
  logic        exp_rv_a, exp_rv_b;
  logic [15:0] exp_rdata;
  logic        last_ga, last_gb;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic cycle();
    logic          ea, eb;
    logic [1:0]    ewe;
    logic [AMSB:0] eaddr;
    logic [15:0]   edin;
    #1;
    ea = 1'b0;
    eb = 1'b0;
    if (!puc_rst) begin
      if (owner == 1)                        ea = req_a;
      else if (owner == 2)                   eb = req_b;
      else if (req_b && blocked >= int'(MAXW)) eb = 1'b1;
      else if (req_a)                        ea = 1'b1;
      else if (req_b)                        eb = 1'b1;
    end
    ewe   = ea ? we_a   : eb ? we_b   : 2'b00;
    eaddr = ea ? addr_a : eb ? addr_b : '0;
    edin  = ea ? din_a  : eb ? din_b  : 16'h0;

    check("gnt_a",    32'(gnt_a),    32'(ea));
    check("gnt_b",    32'(gnt_b),    32'(eb));
    check("ram_en",   32'(ram_en),   32'(ea | eb));
    check("ram_we",   32'(ram_we),   32'(ewe));
    check("ram_addr", 32'(ram_addr), 32'(eaddr));
    check("ram_din",  32'(ram_din),  32'(edin));
    check("rvalid_a", 32'(rvalid_a), 32'(exp_rv_a));
    check("rvalid_b", 32'(rvalid_b), 32'(exp_rv_b));
    if (exp_rv_a || exp_rv_b) check("rdata", 32'(rdata), 32'(exp_rdata));
    last_ga = gnt_a;
    last_gb = gnt_b;

    exp_rv_a = ea && (we_a == 2'b00);
    exp_rv_b = eb && (we_b == 2'b00);
    if ((ea || eb) && ewe == 2'b00) exp_rdata = shadow[eaddr];
    if (ea || eb) begin
      if (ewe[0]) shadow[eaddr][7:0]  = edin[7:0];
      if (ewe[1]) shadow[eaddr][15:8] = edin[15:8];
    end

    if (owner == 0) begin
      if (ea && lock_a)      owner = 1;
      else if (eb && lock_b) owner = 2;
    end else if (owner == 1) begin
      if (!req_a || !lock_a) owner = 0;
    end else begin
      if (!req_b || !lock_b) owner = 0;
    end
    if (req_b && !eb) blocked = (blocked < int'(MAXW)) ? blocked + 1 : blocked;
    else              blocked = 0;

    if (puc_rst) begin
      owner    = 0;
      blocked  = 0;
      exp_rv_a = 1'b0;
      exp_rv_b = 1'b0;
    end
    @(posedge mclk);
    @(negedge mclk);
  endtask

  task automatic quiet();
    req_a = 1'b0; req_b = 1'b0; lock_a = 1'b0; lock_b = 1'b0;
    we_a = 2'b00; we_b = 2'b00; addr_a = '0; addr_b = '0;
    din_a = 16'h0; din_b = 16'h0;
  endtask

  task automatic set_a(input logic r, input logic [1:0] w, input int unsigned a,
                       input logic [15:0] d, input logic l);
    req_a = r; we_a = w; addr_a = AMSB'(a); din_a = d; lock_a = l;
  endtask

  task automatic set_b(input logic r, input logic [1:0] w, input int unsigned a,
                       input logic [15:0] d, input logic l);
    req_b = r; we_b = w; addr_b = AMSB'(a); din_b = d; lock_b = l;
  endtask

  initial begin
    logic [14:0] gseq;
    owner = 0; blocked = 0; exp_rv_a = 1'b0; exp_rv_b = 1'b0; exp_rdata = 16'h0;
    quiet();
    puc_rst = 1'b1;
    pl_en = 1'b0; pl_addr = '0; pl_data = 16'h0;
    @(negedge mclk);

    // Preload under reset with random requests that must stay ungranted.
    for (int unsigned i = 0; i < 64; i++) begin
      pl_en   = 1'b1;
      pl_addr = AMSB'(i);
      pl_data = (i == 32'h10) ? 16'hBEEF : (i == 32'h30) ? 16'h1234 : 16'($urandom);
      shadow[pl_addr] = pl_data;
      req_a = 1'($urandom); req_b = 1'($urandom);
      cycle();
    end
    pl_en = 1'b0;
    quiet();
    puc_rst = 1'b0;
    cycle();
    check("rst_rvalid_a", 32'(rvalid_a), 32'd0);

    // Solo read from B.
    set_b(1'b1, 2'b00, 32'h10, 16'h0, 1'b0);
    cycle();
    check("solo_gnt_b", 32'(last_gb), 32'd1);
    quiet();
    check("solo_rvalid_b", 32'(rvalid_b), 32'd1);
    check("solo_rdata", 32'(rdata), 32'hBEEF);
    cycle();

    // Both requesting continuously: B every fifth cycle.
    set_a(1'b1, 2'b00, 32'h01, 16'h0, 1'b0);
    set_b(1'b1, 2'b00, 32'h02, 16'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      cycle();
      gseq[i] = last_gb;
    end
    for (int i = 0; i < 15; i++)
      check("starve_seq", 32'(gseq[i]), 32'((i % 5) == 4));
    quiet();
    cycle();

    // Locked write burst by B while A waits.
    set_b(1'b1, 2'b11, 32'h20, 16'h1111, 1'b1);
    cycle();
    set_a(1'b1, 2'b00, 32'h05, 16'h0, 1'b0);
    set_b(1'b1, 2'b11, 32'h21, 16'h2222, 1'b1);
    cycle();
    check("burst_gnt_a_blocked", 32'(last_ga), 32'd0);
    set_b(1'b1, 2'b11, 32'h22, 16'h3333, 1'b0);
    cycle();
    check("burst_last_gnt_a", 32'(last_ga), 32'd0);
    set_b(1'b0, 2'b00, 32'h0, 16'h0, 1'b0);
    cycle();
    check("burst_then_a", 32'(last_ga), 32'd1);
    quiet();
    set_b(1'b1, 2'b00, 32'h20, 16'h0, 1'b0);
    cycle();
    check("burst_rd0", 32'(rdata), 32'h1111);
    addr_b = 12'h21;
    cycle();
    check("burst_rd1", 32'(rdata), 32'h2222);
    check("burst_rd1_rvalid", 32'(rvalid_b), 32'd1);
    addr_b = 12'h22;
    cycle();
    check("burst_rd2", 32'(rdata), 32'h3333);
    quiet();
    cycle();

    // Byte write to low lane.
    set_a(1'b1, 2'b01, 32'h30, 16'hAA55, 1'b0);
    cycle();
    check("bytewr_no_rvalid", 32'(rvalid_a), 32'd0);
    set_a(1'b1, 2'b00, 32'h30, 16'h0, 1'b0);
    cycle();
    check("bytewr_readback", 32'(rdata), 32'h1255);
    quiet();
    cycle();

    // Lock release by dropping the request.
    set_a(1'b1, 2'b00, 32'h01, 16'h0, 1'b1);
    cycle();
    set_a(1'b0, 2'b00, 32'h01, 16'h0, 1'b0);
    set_b(1'b1, 2'b00, 32'h03, 16'h0, 1'b0);
    cycle();
    check("release_no_gnt", 32'({last_ga, last_gb}), 32'd0);
    cycle();
    check("release_then_b", 32'(last_gb), 32'd1);
    quiet();
    cycle();

    // Reset while B holds a lock.
    set_b(1'b1, 2'b00, 32'h04, 16'h0, 1'b1);
    cycle();
    set_a(1'b1, 2'b00, 32'h06, 16'h0, 1'b0);
    cycle();
    puc_rst = 1'b1;
    cycle();
    check("rst_lock_ram_en", 32'({last_ga, last_gb}), 32'd0);
    puc_rst = 1'b0;
    check("rst_lock_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
    cycle();
    check("rst_lock_a_first", 32'(last_ga), 32'd1);
    quiet();
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      puc_rst = ($urandom_range(0, 99) == 0);
      set_a(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
            $urandom_range(0, 63), 16'($urandom), ($urandom_range(0, 3) == 0));
      set_b(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3) == 0 ? $urandom : 0),
            $urandom_range(0, 63), 16'($urandom), ($urandom_range(0, 3) == 0));
      cycle();
    end
    puc_rst = 1'b0;
    quiet();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
